// File: rtl/serial_mult_pkg.sv
// serial_mult_pkg: shared word length default, FSM encoding and counter-width helper
package serial_mult_pkg;
  localparam int NB_DATA_IN_DEF = 4;
  typedef enum logic {IDLE, SHIFT} state_t;
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/serial_operand_tx_if.sv
// serial_operand_tx_if: parallel operand handshake and serial output bundle
interface serial_operand_tx_if import serial_mult_pkg::*; #(parameter int NB_DATA_IN = NB_DATA_IN_DEF);
  logic [NB_DATA_IN-1:0] i_data_a;
  logic [NB_DATA_IN-1:0] i_data_b;
  logic                  i_valid;
  logic                  o_ready;
  logic                  o_data_a;
  logic                  o_data_b;
  logic                  o_en;
  logic                  o_frame;
  logic                  o_busy;
  modport master (output i_data_a, i_data_b, i_valid, input o_ready, o_data_a, o_data_b, o_en, o_frame, o_busy);
  modport slave  (input i_data_a, i_data_b, i_valid, output o_ready, o_data_a, o_data_b, o_en, o_frame, o_busy);
endinterface

// File: rtl/operand_fifo.sv
// operand_fifo: synchronous FIFO buffering operand pairs, power-of-2 depth
module operand_fifo import serial_mult_pkg::*; #(
  parameter int WIDTH = 2 * NB_DATA_IN_DEF,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp, rp;
  logic             wr, rd;
  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign wr    = push & ~full;
  assign rd    = pop & ~empty;
  assign dout  = mem[rp];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      wp    <= wp + AW'(wr);
      rp    <= rp + AW'(rd);
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
  always_ff @(posedge clk)
    if (wr) mem[wp] <= din;
endmodule

// File: rtl/serial_operand_tx.sv
// serial_operand_tx: buffers parallel operand pairs and shifts them out LSB-first
module serial_operand_tx import serial_mult_pkg::*; #(
  parameter int NB_DATA_IN = NB_DATA_IN_DEF,
  parameter int FIFO_DEPTH = 2
) (
  input logic                clk,
  input logic                i_rst,
  serial_operand_tx_if.slave bus
);
  localparam int NBC = clog2_min1(NB_DATA_IN);
  localparam int NBF = $clog2(FIFO_DEPTH) + 1;
  state_t                  state, state_n;
  logic [NBC-1:0]          cnt, cnt_n;
  logic [NB_DATA_IN-1:0]   sa, sb, sa_n, sb_n;
  logic [2*NB_DATA_IN-1:0] dout;
  logic [NBF-1:0]          count;
  logic                    full, empty, accept, last, pop, direct, push;
  assign accept = bus.i_valid & ~full;
  assign last   = (state == SHIFT) && (cnt == NBC'(NB_DATA_IN - 1));
  assign pop    = last & ~empty;
  // the buffer drains first; only an empty buffer lets a new pair skip it
  assign direct = accept & ((state == IDLE) | (last & empty));
  assign push   = accept & ~direct;
  operand_fifo #(.WIDTH(2 * NB_DATA_IN), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (i_rst),
    .push  (push),
    .pop   (pop),
    .din   ({bus.i_data_b, bus.i_data_a}),
    .dout  (dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );
  always_comb begin
    state_n = state;
    cnt_n   = cnt + NBC'(1);
    sa_n    = sa >> 1;
    sb_n    = sb >> 1;
    if (pop | direct) begin
      state_n = SHIFT;
      cnt_n   = '0;
      sa_n    = pop ? dout[NB_DATA_IN-1:0] : bus.i_data_a;
      sb_n    = pop ? dout[2*NB_DATA_IN-1:NB_DATA_IN] : bus.i_data_b;
    end else if ((state == IDLE) | last) begin
      state_n = IDLE;
      cnt_n   = '0;
      sa_n    = '0;
      sb_n    = '0;
    end
  end
  always_ff @(posedge clk or posedge i_rst)
    if (i_rst) begin
      state <= IDLE;
      cnt   <= '0;
      sa    <= '0;
      sb    <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      sa    <= sa_n;
      sb    <= sb_n;
    end
  // shift regs are cleared whenever idle, so bit 0 alone drives the lines
  assign bus.o_data_a = sa[0];
  assign bus.o_data_b = sb[0];
  assign bus.o_en     = state == SHIFT;
  assign bus.o_frame  = (state == SHIFT) && (cnt == '0);
  assign bus.o_busy   = (state == SHIFT) | (count != '0);
  assign bus.o_ready  = ~full;
endmodule
